diviac_seq_divider: RTL
=======================

DIVIAC_SEQ_DIVIDER -- requirements
Module: diviac_seq_divider

Interface
REQ-001 SHALL provide parameter N, default 8, meaning divisor/quotient/remainder width (legal 2..32).
REQ-002 SHALL provide parameter APPROX_ROWS, default 4, meaning count of least-significant quotient rows built from approximate cells (legal 0..N).
REQ-003 SHALL provide port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL provide port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL provide port start, input, 1, request to begin a division; sampled only while ready=1.
REQ-006 SHALL provide port n, input, 2N, dividend; captured on accepted start.
REQ-007 SHALL provide port d, input, N, divisor; captured on accepted start.
REQ-008 SHALL provide port ready, output, 1, high in IDLE only.
REQ-009 SHALL provide port done, output, 1, one-cycle pulse marking valid q/r.
REQ-010 SHALL provide port q, output, N, registered quotient.
REQ-011 SHALL provide port r, output, N, registered remainder.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE after row 0; DONE->IDLE unconditionally next cycle.
REQ-013 SHALL evaluate exactly one quotient row per RUN cycle, row index k counting N-1 down to 0; start at edge t gives done=1 in cycle t+N+1.
REQ-014 SHALL load on accept: partial remainder P (N+1 bits) = n[2N-1:N-1], divisor register D = d, captured dividend n held for shifting.
REQ-015 SHALL compute per row: x = P[N-1:0]; ripple-borrow subtract x - D, LSB borrow-in 0; q[k] = P[N] OR NOT(final borrow); R = q[k] ? diff : x.
REQ-016 SHALL form next P = {R, n[k-1]} for k>0; for k=0, r = R.
REQ-017 SHALL use exact cells for rows k >= APPROX_ROWS: diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-018 SHALL use approximate cells in every bit of rows k < APPROX_ROWS: diff = 1; bout = NOT(x & ~y & ~bin).
REQ-019 SHALL hold q and r stable from the done cycle until the next accepted start; q/r unchanged while RUN.
REQ-020 SHALL ignore start while RUN or DONE; n/d changes after accept SHALL not affect the result.
REQ-021 SHALL treat d=0 with no special case: result is whatever REQ-015..REQ-018 produce (exact rows give q bit 1, R = x).
REQ-022 SHALL give no overflow detection: n[2N-1:N] >= d yields the array-defined result.

Reset
REQ-023 SHALL on rst=1 at a clock edge force IDLE, ready=1, done=0, q=0, r=0, row counter=0, P=0, D=0, in any state including mid-RUN.
REQ-024 SHALL, when rst and start are both high, give rst priority; the start is not accepted.

Configuration
REQ-025 SHALL honour macro DIVIAC_APPROX_ROWS_EN: defined -> REQ-018 applies to rows k < APPROX_ROWS; undefined -> all rows use exact cells regardless of APPROX_ROWS (bit-exact restoring divider).

Verification
REQ-026 SHALL cover exact path (macro undefined, N=8): n=100, d=7 -> done at t+9, q=14, r=2.
REQ-027 SHALL cover approximate path (macro defined, N=8, APPROX_ROWS=4): n=100, d=7 -> q=0, r=100.
REQ-028 SHALL cover APPROX_ROWS=0 with macro defined: n=1000, d=13 -> q=76, r=12, identical to exact.
REQ-029 SHALL cover busy rejection: start with n=100, d=7, then start=1 with n=50, d=5 during RUN -> single done, result of first operation only.
REQ-030 SHALL cover reset mid-operation: rst=1 at row 3 -> next cycle ready=1, done=0, q=0, r=0; subsequent start n=100, d=7 completes normally.
REQ-031 SHALL cover back-to-back: start asserted in the cycle after done (IDLE) -> accepted; q/r from first result held until second done.

Source files
------------

// File: rtl/diviac_seq_divider.sv
// Sequential 2N/N restoring divider, one quotient row per cycle, optional approximate low rows.
// Latency: start accepted at edge t -> done pulse in cycle t+N+1; q/r held until next accepted start.
// Backpressure: ready=1 only in IDLE; start ignored while busy. Macro DIVIAC_APPROX_ROWS_EN enables approximate rows.
module diviac_seq_divider #(
  parameter int N           = 8,
  parameter int APPROX_ROWS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] n,
  input  logic [N-1:0]   d,
  output logic           ready,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

`ifdef DIVIAC_APPROX_ROWS_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  // One extra bit so APPROX_ROWS == N (every row approximate) is representable.
  localparam logic [KW:0] APPROX_LIM = (KW+1)'(APPROX_ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N:0]    p;      // partial remainder
  logic [N-1:0]  dr;     // captured divisor
  logic [N-2:0]  nlo;    // low dividend bits still to be shifted into P, MSB first
  logic [KW-1:0] k;      // current quotient row index
  logic [N-1:0]  qacc;   // quotient bits collected so far

  logic [N-1:0]  x;
  logic [N-1:0]  diff;
  logic [N-1:0]  rem;
  logic [N-1:0]  qnxt;
  logic [N:0]    bw;
  logic          qbit;
  logic          use_approx;

  // Row evaluation: ripple-borrow subtract of the divisor from the low N bits of P.
  always_comb begin
    x          = p[N-1:0];
    use_approx = APPROX_EN && ({1'b0, k} < APPROX_LIM);
    bw         = '0;
    diff       = '0;
    for (int i = 0; i < N; i++) begin
      if (use_approx) begin
        // Approximate cell: difference pinned high, borrow only cleared on the x=1,y=0,bin=0 case.
        diff[i]  = 1'b1;
        bw[i+1]  = ~(x[i] & ~dr[i] & ~bw[i]);
      end else begin
        diff[i]  = x[i] ^ dr[i] ^ bw[i];
        bw[i+1]  = (~x[i] & dr[i]) | (~(x[i] ^ dr[i]) & bw[i]);
      end
    end
    // P[N] set means the true partial remainder already exceeds any N-bit divisor.
    qbit    = p[N] | ~bw[N];
    rem     = qbit ? diff : x;
    qnxt    = qacc;
    qnxt[k] = qbit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (k == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready = (state == S_IDLE);
    done  = (state == S_DONE);
  end

  // Datapath: capture operands on accept, step one row per RUN cycle, publish q/r after row 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= '0;
      dr   <= '0;
      nlo  <= '0;
      k    <= '0;
      qacc <= '0;
      q    <= '0;
      r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            p    <= n[2*N-1:N-1];
            dr   <= d;
            nlo  <= n[N-2:0];
            k    <= KW'(N-1);
            qacc <= '0;
          end
        end
        S_RUN: begin
          qacc <= qnxt;
          p    <= {rem, nlo[N-2]};
          nlo  <= nlo << 1;
          if (k == '0) begin
            q <= qnxt;
            r <= rem;
          end else begin
            k <= k - KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
